instr_decode_reg: RTL
=====================

INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 Parameter: OPC_LEGAL_MAX, default 6'h0F, highest legal opcode; used only when ILLEGAL_OP_CHECK_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream fetch presents instr/pc this cycle.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-006 instr  input  32  fetched instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 flush  input  1  discard all held entries (branch redirect).
REQ-009 out_valid  output  1  decoded entry presented downstream.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 opcode  output  6  instr[31:26] of head entry.
REQ-012 rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
REQ-013 shamt  output  5  instr[10:6].
REQ-014 funct  output  6  instr[5:0].
REQ-015 imm16  output  16  instr[15:0], raw and unextended; feeds the sign-extend stage.
REQ-016 pc_out  output  32  pc of head entry.
REQ-017 illegal  output  1  head entry opcode exceeds OPC_LEGAL_MAX.

Function
REQ-018 Storage: two-entry skid buffer (head, skid); states EMPTY, ONE, TWO.
REQ-019 in_ready = 1 in EMPTY and ONE; 0 in TWO; registered, never combinationally dependent on out_ready.
REQ-020 out_valid = 1 in ONE and TWO; all decoded outputs are fields of the head entry only.
REQ-021 EMPTY: accept -> ONE (head <= input); latency input accept to out_valid = 1 cycle.
REQ-022 ONE: accept and no drain -> TWO (skid <= input); drain and no accept -> EMPTY; accept and drain simultaneously -> ONE with head <= input.
REQ-023 TWO: drain -> ONE, head <= skid; no accept possible in TWO.
REQ-024 Order preserved: entries leave in acceptance order; no entry duplicated or dropped except by flush/rst.
REQ-025 Field outputs hold stable while out_valid && !out_ready.
REQ-026 flush: next state EMPTY regardless of state, in_valid, out_ready; an input presented in the flush cycle is discarded.
REQ-027 Field outputs when out_valid = 0 are don't-care for verification but must not be X after reset (retain last or zero).

Reset
REQ-028 rst has priority over flush and all handshakes; next state EMPTY.
REQ-029 Post-reset values: out_valid 0, in_ready 1, illegal 0, opcode/rs/rt/rd/shamt/funct/imm16 0, pc_out 32'h0.
REQ-030 rst asserted mid-operation drops both held entries; first accept after rst deassertion behaves as from EMPTY.

Configuration
REQ-031 Macro ILLEGAL_OP_CHECK_EN defined: illegal = out_valid && (opcode > OPC_LEGAL_MAX), computed at accept time and stored per entry.
REQ-032 Macro ILLEGAL_OP_CHECK_EN undefined: illegal tied to 0; no comparator logic; OPC_LEGAL_MAX unused.

Verification
REQ-033 rst then instr=32'h1422FFFC, pc=32'h100, out_ready=1 -> next cycle out_valid=1, opcode=6'h05, rs=1, rt=2, imm16=16'hFFFC, pc_out=32'h100.
REQ-034 out_ready=0, accept A (pc 0x0) and B (pc 0x4) -> state TWO, in_ready=0, head A stable; raise out_ready -> A then B in consecutive cycles, then out_valid=0.
REQ-035 ONE state, simultaneous accept C and drain of head -> stays ONE, next head = C, no bubble, no loss.
REQ-036 TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input in flush cycle not emitted.
REQ-037 With ILLEGAL_OP_CHECK_EN, instr opcode 6'h10 -> illegal=1 with that entry; opcode 6'h0F -> illegal=0; without macro illegal=0 for both.
REQ-038 rst asserted in TWO with in_valid=1, out_ready=1 -> next cycle all outputs at REQ-029 values.

Source files
------------

// File: rtl/instr_decode_reg.sv
// ---------------------------------------------------------------------------
// instr_decode_reg
//
// Decode register between instruction fetch and the rest of the decode
// pipeline. A two-entry skid buffer (head + skid) holds fetched instruction
// words. The head entry's fields are presented downstream. Because in_ready
// is a decode of the state register only, the upstream ready path never
// depends combinationally on out_ready.
//
// Optional feature macro: ILLEGAL_OP_CHECK_EN
//   defined   : each entry carries an "opcode > OPC_LEGAL_MAX" flag computed
//               when the entry is accepted; illegal reports the head's flag.
//   undefined : illegal is tied low and no comparator is built.
//
// Parameters
//   OPC_LEGAL_MAX  highest legal opcode (used only with ILLEGAL_OP_CHECK_EN)
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   fetch presents instr/pc
//   in_ready   out  1   buffer can accept (low only when both entries full)
//   instr      in   32  fetched instruction word
//   pc         in   32  address of instr
//   flush      in   1   discard every held entry (branch redirect)
//   out_valid  out  1   head entry is valid
//   out_ready  in   1   downstream takes the head entry
//   opcode     out  6   head instr[31:26]
//   rs/rt/rd   out  5   head instr[25:21] / [20:16] / [15:11]
//   shamt      out  5   head instr[10:6]
//   funct      out  6   head instr[5:0]
//   imm16      out  16  head instr[15:0], not extended
//   pc_out     out  32  head pc
//   illegal    out  1   head opcode exceeds OPC_LEGAL_MAX
// ---------------------------------------------------------------------------
module instr_decode_reg #(
    parameter logic [5:0] OPC_LEGAL_MAX = 6'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] pc_out,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_drain;
    logic        w_load_head_in;    // head <= incoming word
    logic        w_load_head_skid;  // head <= skid (skid promotes)
    logic        w_load_skid;       // skid <= incoming word

    logic [31:0] r_head_instr;
    logic [31:0] r_head_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);

    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and load-enable decode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // Held entries and any word presented this cycle are dropped.
            w_state_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        // Pass-through: new word replaces the departing head.
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_drain) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        w_state_next     = ST_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the data registers are reset (not just the valid state) because
    // the decoded fields must read as zero, never X, straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_instr <= '0;
            r_head_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head_instr <= instr;
                r_head_pc    <= pc;
            end else if (w_load_head_skid) begin
                r_head_instr <= r_skid_instr;
                r_head_pc    <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_instr <= instr;
                r_skid_pc    <= pc;
            end
        end
    end

    // Field split of the head entry.
    assign opcode = r_head_instr[31:26];
    assign rs     = r_head_instr[25:21];
    assign rt     = r_head_instr[20:16];
    assign rd     = r_head_instr[15:11];
    assign shamt  = r_head_instr[10:6];
    assign funct  = r_head_instr[5:0];
    assign imm16  = r_head_instr[15:0];
    assign pc_out = r_head_pc;

    // -----------------------------------------------------------------------
    // Illegal-opcode flag
    // -----------------------------------------------------------------------
`ifdef ILLEGAL_OP_CHECK_EN
    logic w_in_illegal;
    logic r_head_illegal;
    logic r_skid_illegal;

    // Evaluated once at accept time and carried with the entry.
    assign w_in_illegal = (instr[31:26] > OPC_LEGAL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_illegal <= 1'b0;
            r_skid_illegal <= 1'b0;
        end else begin
            if (w_load_head_in) begin
                r_head_illegal <= w_in_illegal;
            end else if (w_load_head_skid) begin
                r_head_illegal <= r_skid_illegal;
            end
            if (w_load_skid) begin
                r_skid_illegal <= w_in_illegal;
            end
        end
    end

    assign illegal = out_valid && r_head_illegal;
`else
    // Check disabled: the limit parameter only feeds an unused reduction.
    logic w_unused_cfg;
    assign w_unused_cfg = ^OPC_LEGAL_MAX;
    assign illegal      = 1'b0;
`endif

endmodule
